// File: rtl/midi_pitch_tx.sv
// midi_pitch_tx: 8N1 MIDI transmitter for 14-bit pitch-bend messages with optional running status
module midi_pitch_tx #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD = 31250,
    parameter int DIV = CLK_HZ / BAUD,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic        CLOCK_25,
    input  logic        reset_data,
    input  logic        pitch_cmd,
    input  logic [13:0] pitch_val,
    input  logic [3:0]  midi_ch,
    output logic        midi_txd,
    output logic        busy,
    output logic        msg_done
);
    localparam int BW = $clog2(DIV);
    typedef enum logic [1:0] {IDLE, STATUS, DATA_LSB, DATA_MSB} state_t;
    state_t state, state_nx;
    logic [BW-1:0] baud_cnt;
    logic [3:0] bit_cnt;
    logic [9:0] frame, frame_nx;
    logic [13:0] cur_val, hold_val, src_val;
    logic [3:0] hold_ch, src_ch;
    logic [7:0] last_status;
    logic pending, go, bit_end, byte_end, start, need_status, done_nx;
    always_comb begin
        go = pitch_cmd | pending;
        src_ch = pitch_cmd ? midi_ch : hold_ch;
        src_val = pitch_cmd ? pitch_val : hold_val;
        need_status = !RUNNING_STATUS || {4'hE, src_ch} != last_status;
        bit_end = baud_cnt == BW'(DIV - 1);
        byte_end = bit_end && bit_cnt == 4'd9;
        done_nx = state == DATA_MSB && byte_end;
        // A pending message chains straight onto the last stop bit with no idle gap
        start = go && (state == IDLE || done_nx);
        state_nx = state;
        frame_nx = bit_end ? {1'b1, frame[9:1]} : frame;
        if (start) begin
            state_nx = need_status ? STATUS : DATA_LSB;
            frame_nx = need_status ? {1'b1, 4'hE, src_ch, 1'b0} : {2'b10, src_val[6:0], 1'b0};
        end else if (byte_end) begin
            state_nx = state == STATUS ? DATA_LSB : state == DATA_LSB ? DATA_MSB : IDLE;
            frame_nx = state == STATUS ? {2'b10, cur_val[6:0], 1'b0} :
                       state == DATA_LSB ? {2'b10, cur_val[13:7], 1'b0} : '1;
        end
    end
    always_ff @(posedge CLOCK_25 or posedge reset_data) begin
        if (reset_data) begin
            state <= IDLE;
            baud_cnt <= '0;
            bit_cnt <= '0;
            frame <= '1;
            cur_val <= '0;
            hold_val <= '0;
            hold_ch <= '0;
            last_status <= 8'h00;
            pending <= 1'b0;
            msg_done <= 1'b0;
        end else begin
            state <= state_nx;
            frame <= frame_nx;
            msg_done <= done_nx;
            if (start) begin
                baud_cnt <= '0;
                bit_cnt <= '0;
                cur_val <= src_val;
                if (need_status) last_status <= {4'hE, src_ch};
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
                bit_cnt <= byte_end ? 4'd0 : bit_end ? bit_cnt + 4'd1 : bit_cnt;
            end
            if (pitch_cmd) begin
                hold_ch <= midi_ch;
                hold_val <= pitch_val;
            end
            pending <= start ? 1'b0 : pitch_cmd ? 1'b1 : pending;
        end
    end
    assign midi_txd = frame[0];
    assign busy = state != IDLE || pending;
endmodule

// File: tb/tb_midi_pitch_tx.sv
// tb_midi_pitch_tx: decodes the serial line of two transmitters (running status on/off) against a byte-level model
module tb_midi_pitch_tx;
    localparam int DIV = 16;
    logic CLOCK_25 = 1'b0, reset_data = 1'b0, cmd0 = 1'b0, cmd1 = 1'b0;
    logic [13:0] pitch_val = '0;
    logic [3:0] midi_ch = '0;
    logic txd0, txd1, busy0, busy1, done0, done1;
    int errors = 0, checks = 0;
    logic [7:0] ls [2];
    logic [7:0] expq [$];

    always #5 CLOCK_25 = ~CLOCK_25;

    midi_pitch_tx #(.CLK_HZ(DIV * 31250), .BAUD(31250), .RUNNING_STATUS(1'b1)) dut0 (
        .CLOCK_25(CLOCK_25), .reset_data(reset_data), .pitch_cmd(cmd0), .pitch_val(pitch_val),
        .midi_ch(midi_ch), .midi_txd(txd0), .busy(busy0), .msg_done(done0));
    midi_pitch_tx #(.CLK_HZ(DIV * 31250), .BAUD(31250), .RUNNING_STATUS(1'b0)) dut1 (
        .CLOCK_25(CLOCK_25), .reset_data(reset_data), .pitch_cmd(cmd1), .pitch_val(pitch_val),
        .midi_ch(midi_ch), .midi_txd(txd1), .busy(busy1), .msg_done(done1));

    function automatic logic txd_of(input int sel);
        return sel != 0 ? txd1 : txd0;
    endfunction
    function automatic logic busy_of(input int sel);
        return sel != 0 ? busy1 : busy0;
    endfunction
    function automatic logic done_of(input int sel);
        return sel != 0 ? done1 : done0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
    endtask

    task automatic set_cmd(input int sel, input logic v);
        if (sel != 0) cmd1 = v;
        else cmd0 = v;
    endtask

    task automatic idle_check(input int sel, input string tag);
        chk({tag, "_txd"}, 32'(txd_of(sel)), 32'd1);
        chk({tag, "_busy"}, 32'(busy_of(sel)), 32'd0);
        chk({tag, "_done"}, 32'(done_of(sel)), 32'd0);
    endtask

    // Expected bytes of one message: status only when it differs from the last one sent (or running status is off)
    task automatic build(input int sel, input logic [3:0] ch, input logic [13:0] v);
        expq.delete();
        if (sel == 1 || ls[sel] != {4'hE, ch}) begin
            expq.push_back({4'hE, ch});
            ls[sel] = {4'hE, ch};
        end
        expq.push_back({1'b0, v[6:0]});
        expq.push_back({1'b0, v[13:7]});
    endtask

    // lead=1: message loads on the first edge after the call; lead=0: it already loaded on the current edge
    task automatic observe(input int sel, input int lead, input bit mid, input logic [13:0] v1, input logic [13:0] v2);
        int last = lead + expq.size() * 10 * DIV;
        logic [9:0] fr = '1;
        for (int c = 1; c <= last; c++) begin
            tick();
            if (c == 1) begin
                set_cmd(sel, 1'b0);
                chk("busy_start", 32'(busy_of(sel)), 32'd1);
            end
            if (mid && c == 5 * DIV) begin pitch_val = v1; set_cmd(sel, 1'b1); end
            if (mid && c == 20 * DIV) begin pitch_val = v2; set_cmd(sel, 1'b1); end
            if (mid && (c == 5 * DIV + 1 || c == 20 * DIV + 1)) set_cmd(sel, 1'b0);
            if (c >= lead && (c - lead) % DIV == DIV / 2) begin
                int j = (c - lead) / DIV;
                fr[j % 10] = txd_of(sel);
                if (j % 10 == 9) chk($sformatf("byte%0d", j / 10), 32'(fr), 32'({1'b1, expq[j / 10], 1'b0}));
            end
            if (c == last - 1) chk("done_early", 32'(done_of(sel)), 32'd0);
        end
        chk("done_pulse", 32'(done_of(sel)), 32'd1);
    endtask

    task automatic send(input int sel, input logic [3:0] ch, input logic [13:0] v);
        midi_ch = ch;
        pitch_val = v;
        build(sel, ch, v);
        set_cmd(sel, 1'b1);
        observe(sel, 1, 1'b0, '0, '0);
        tick();
        idle_check(sel, "after_msg");
    endtask

    initial begin
        ls[0] = 8'h00;
        ls[1] = 8'h00;
        #2 reset_data = 1'b1;
        #1;
        idle_check(0, "reset0");
        idle_check(1, "reset1");
        tick();
        tick();
        reset_data = 1'b0;
        tick();
        send(0, 4'd0, 14'd8192);
        send(0, 4'd0, 14'd16383);
        send(1, 4'd0, 14'd16383);
        send(0, 4'd15, 14'd8192);
        // Two strobes during a message coalesce into one follow-on message carrying the newest value
        midi_ch = 4'd0;
        pitch_val = 14'd8192;
        build(0, 4'd0, 14'd8192);
        set_cmd(0, 1'b1);
        observe(0, 1, 1'b1, 14'd100, 14'd200);
        chk("pending_busy", 32'(busy0), 32'd1);
        build(0, 4'd0, 14'd200);
        observe(0, 0, 1'b0, '0, '0);
        tick();
        idle_check(0, "after_chain");
        repeat (3 * DIV) tick();
        idle_check(0, "no_extra");
        // Asynchronous reset in the middle of the LSB byte
        midi_ch = 4'd5;
        pitch_val = 14'd12345;
        set_cmd(0, 1'b1);
        tick();
        set_cmd(0, 1'b0);
        repeat (14 * DIV + DIV / 2) tick();
        chk("mid_busy", 32'(busy0), 32'd1);
        #2 reset_data = 1'b1;
        #1;
        idle_check(0, "async_reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold_txd", 32'(txd0), 32'd1);
        end
        reset_data = 1'b0;
        ls[0] = 8'h00;
        ls[1] = 8'h00;
        tick();
        send(0, 4'd0, 14'd0);
        for (int i = 0; i < 8; i++) begin
            int sel = int'($urandom_range(0, 1));
            send(sel, 4'($urandom_range(0, 2)), 14'($urandom));
            repeat ($urandom_range(1, 4)) tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
